// File: rtl/counter_pkg.sv
// counter_pkg: shared direction constants and width helper for the counter library
package counter_pkg;
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic int min_width(input longint unsigned modulus);
        int w;
        w = 1;
        while (w < 64 && (64'd1 << w) < modulus) w++;
        return w;
    endfunction
endpackage

// File: rtl/dff_bank.sv
// dff_bank: WIDTH-bit D register with synchronous active-low reset to a parameter value
module dff_bank #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clock) q <= !reset_n ? RESET_VALUE : d;
endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: modulo-N up/down counter with load, cascadable tc and wrap/load-error pulses
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH       = 4,
    parameter longint unsigned MODULUS     = 10,
    parameter longint unsigned RESET_VALUE = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrapped,
    output logic             load_err
);
    localparam logic [WIDTH-1:0] MAX     = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || MODULUS > (64'd1 << WIDTH) ||
        RESET_VALUE >= MODULUS || min_width(MODULUS) > WIDTH) begin : g_bad_params
        $error("updown_mod_counter: illegal WIDTH/MODULUS/RESET_VALUE");
    end

    logic             at_top, at_zero, in_range, wrap_d, err_d;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        at_top   = count == MAX;
        at_zero  = count == '0;
        in_range = {1'b0, load_value} < MOD_EXT;
        tc       = enable & (up == DIR_UP ? at_top : at_zero);
        count_d  = load ? (in_range ? load_value : MAX) :
                   !enable ? count :
                   up == DIR_UP ? (at_top ? '0 : count + WIDTH'(1)) :
                   (at_zero ? MAX : count - WIDTH'(1));
        wrap_d   = !load & tc;
        err_d    = load & !in_range;
    end

    dff_bank #(.WIDTH(WIDTH), .RESET_VALUE(WIDTH'(RESET_VALUE))) u_count (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (count_d),
        .q       (count)
    );

    always_ff @(posedge clock) begin
        wrapped  <= reset_n & wrap_d;
        load_err <= reset_n & err_d;
    end
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: random and directed checks against a modular-arithmetic model
module tb_updown_mod_counter;
    localparam int MOD = 10;

    logic       clock = 0;
    logic       reset_n, enable, up, load;
    logic [3:0] load_value;
    logic [3:0] count;
    logic       tc, wrapped, load_err;

    logic       c_rn, c_en;
    logic [3:0] lo_count, hi_count, zero4;
    logic       lo_tc, hi_tc, lo_wrapped, hi_wrapped, lo_err, hi_err;

    int errors = 0;
    int checks = 0;
    int m_count = 0, m_wrapped = 0, m_err = 0;

    always #5 clock = ~clock;

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .count(count), .tc(tc), .wrapped(wrapped), .load_err(load_err)
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dut_lo (
        .clock(clock), .reset_n(c_rn), .enable(c_en), .up(1'b1), .load(1'b0),
        .load_value(zero4), .count(lo_count), .tc(lo_tc), .wrapped(lo_wrapped), .load_err(lo_err)
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dut_hi (
        .clock(clock), .reset_n(c_rn), .enable(lo_tc), .up(1'b1), .load(1'b0),
        .load_value(zero4), .count(hi_count), .tc(hi_tc), .wrapped(hi_wrapped), .load_err(hi_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic rn, input logic ld, input int lv, input logic en, input logic u);
        reset_n = rn; load = ld; load_value = 4'(lv); enable = en; up = u;
        #1;
        check("tc", 32'(tc), 32'(en && (u ? m_count == MOD - 1 : m_count == 0)));
        @(posedge clock);
        if (!rn) begin
            m_count = 0; m_wrapped = 0; m_err = 0;
        end else if (ld) begin
            m_err = lv >= MOD; m_count = m_err ? MOD - 1 : lv; m_wrapped = 0;
        end else if (en) begin
            m_count = (m_count + (u ? 1 : MOD - 1)) % MOD;
            m_wrapped = m_count == (u ? 0 : MOD - 1); m_err = 0;
        end else begin
            m_wrapped = 0; m_err = 0;
        end
        #1;
        check("count", 32'(count), 32'(m_count));
        check("wrapped", 32'(wrapped), 32'(m_wrapped));
        check("load_err", 32'(load_err), 32'(m_err));
    endtask

    initial begin
        int v, hi_wraps;
        zero4 = '0; c_rn = 0; c_en = 0;
        reset_n = 0; enable = 0; up = 1; load = 0; load_value = '0;
        @(posedge clock); #1;
        repeat (2) cyc(0, 0, 0, 0, 1);
        repeat (12) cyc(1, 0, 0, 1, 1);
        cyc(1, 1, 2, 0, 1);
        repeat (4) cyc(1, 0, 0, 1, 0);
        cyc(1, 1, 7, 1, 1);
        cyc(1, 1, 12, 1, 0);
        cyc(1, 1, 15, 0, 1);
        cyc(1, 1, 5, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, (i % 2) == 0);
        cyc(1, 1, 8, 0, 1);
        cyc(0, 1, 3, 1, 1);
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 19) != 0, $urandom_range(0, 7) == 0,
                int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, 1'($urandom));

        c_rn = 0; c_en = 0;
        repeat (2) @(posedge clock);
        #1; c_rn = 1; c_en = 1;
        v = 0; hi_wraps = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock); #1;
            v = (v + 1) % 100;
            check("casc_lo", 32'(lo_count), 32'(v % 10));
            check("casc_hi", 32'(hi_count), 32'(v / 10));
            check("casc_hi_wrapped", 32'(hi_wrapped), 32'(v == 0));
            hi_wraps += int'(hi_wrapped);
        end
        check("casc_hi_wrap_total", 32'(hi_wraps), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
